// File: rtl/prog_pkg.sv
// Shared types and constants for the front-panel programming-mode controller.
// Holds mode encodings, FSM states, per-mode field ranges and range helpers.
package prog_pkg;

  localparam int FIELD_W    = 7;
  localparam int NUM_FIELDS = 3;

  typedef logic [2:0]                            mode_t;
  typedef logic [FIELD_W-1:0]                    field_t;
  typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0]    fields_t;

  localparam mode_t MODE_NONE  = 3'b000;
  localparam mode_t MODE_DATE  = 3'b001;
  localparam mode_t MODE_TIME  = 3'b010;
  localparam mode_t MODE_TIMER = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam field_t DAY_MIN   = 7'd1;
  localparam field_t DAY_MAX   = 7'd31;
  localparam field_t MONTH_MIN = 7'd1;
  localparam field_t MONTH_MAX = 7'd12;
  localparam field_t YEAR_MIN  = 7'd0;
  localparam field_t YEAR_MAX  = 7'd99;
  localparam field_t HOUR_MIN  = 7'd0;
  localparam field_t HOUR_MAX  = 7'd23;
  localparam field_t MIN_MIN   = 7'd0;
  localparam field_t MIN_MAX   = 7'd59;
  localparam field_t SEC_MIN   = 7'd0;
  localparam field_t SEC_MAX   = 7'd59;

  function automatic mode_t mode_decode(input logic [2:0] v);
    mode_t m;
    case (v)
      MODE_DATE, MODE_TIME, MODE_TIMER: m = v;
      default:                          m = MODE_NONE;
    endcase
    return m;
  endfunction

  function automatic field_t field_min(input mode_t m, input logic [1:0] idx);
    field_t v;
    if (m == MODE_DATE) begin
      case (idx)
        2'd0:    v = DAY_MIN;
        2'd1:    v = MONTH_MIN;
        default: v = YEAR_MIN;
      endcase
    end else begin
      case (idx)
        2'd0:    v = HOUR_MIN;
        2'd1:    v = MIN_MIN;
        default: v = SEC_MIN;
      endcase
    end
    return v;
  endfunction

  function automatic field_t field_max(input mode_t m, input logic [1:0] idx);
    field_t v;
    if (m == MODE_DATE) begin
      case (idx)
        2'd0:    v = DAY_MAX;
        2'd1:    v = MONTH_MAX;
        default: v = YEAR_MAX;
      endcase
    end else begin
      case (idx)
        2'd0:    v = HOUR_MAX;
        2'd1:    v = MIN_MAX;
        default: v = SEC_MAX;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/prog_mode_ctrl_if.sv
// Panel-side bus of the programming-mode controller: switches, buttons, RTC snapshot
// and the commit request/acknowledge pair toward the RTC write engine.
interface prog_mode_ctrl_if;
  import prog_pkg::*;

  mode_t   sw;
  logic    btn_next;
  logic    btn_up;
  logic    btn_down;
  fields_t snap;
  logic    wr_ack;
  mode_t   prog;
  logic [1:0] field_sel;
  fields_t edit_data;
  logic    wr_req;
  mode_t   wr_mode;

  modport slave (
    input  sw, btn_next, btn_up, btn_down, snap, wr_ack,
    output prog, field_sel, edit_data, wr_req, wr_mode
  );

  modport master (
    output sw, btn_next, btn_up, btn_down, snap, wr_ack,
    input  prog, field_sel, edit_data, wr_req, wr_mode
  );

endinterface

// File: rtl/sw_debounce.sv
// 2-FF synchronizer plus vector debounce; a new value is accepted DB_CYCLES+1 edges
// after it is first sampled, and any change while counting restarts the count.
module sw_debounce #(
  parameter int DB_CYCLES = 100000,
  parameter int WIDTH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  // r_sync1 != r_sync2 means r_sync2 changes on this edge, so the run starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_acc <= r_sync2;
        r_cnt <= '0;
      end else if (r_sync1 != r_sync2) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_acc;

endmodule

// File: rtl/prog_mode_ctrl.sv
// Mode FSM, field editing and RTC commit handshake; all outputs registered, buttons act next cycle.
// wr_req/wr_mode hold until wr_ack is seen; edits are frozen while the commit is pending.
module prog_mode_ctrl
  import prog_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  prog_mode_ctrl_if.slave  bus
);

  mode_t      w_sw_acc;
  mode_t      w_mode;
  fields_t    w_snap;
  fields_t    w_load;
  field_t     w_cur;
  field_t     w_lo;
  field_t     w_hi;
  field_t     w_edit_val;

  state_t     r_state,     w_state_nxt;
  mode_t      r_prog,      w_prog_nxt;
  logic [1:0] r_field_sel, w_sel_nxt;
  fields_t    r_edit,      w_edit_nxt;
  logic       r_wr_req,    w_wr_req_nxt;
  mode_t      r_wr_mode,   w_wr_mode_nxt;

  sw_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .WIDTH     (3)
  ) u_sw_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raw    (bus.sw),
    .o_stable (w_sw_acc)
  );

  assign w_mode = mode_decode(w_sw_acc);
  assign w_snap = bus.snap;

  // Out-of-range snapshot fields load as that field's minimum for the incoming mode.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if ((w_snap[i] < field_min(w_mode, 2'(i))) || (w_snap[i] > field_max(w_mode, 2'(i))))
        w_load[i] = field_min(w_mode, 2'(i));
      else
        w_load[i] = w_snap[i];
    end
  end

  assign w_cur = r_edit[r_field_sel];
  assign w_lo  = field_min(r_prog, r_field_sel);
  assign w_hi  = field_max(r_prog, r_field_sel);

  always_comb begin
    w_edit_val = w_cur;
    if (bus.btn_up && !bus.btn_down)
      w_edit_val = (w_cur == w_hi) ? w_lo : w_cur + 7'd1;
    else if (bus.btn_down && !bus.btn_up)
      w_edit_val = (w_cur == w_lo) ? w_hi : w_cur - 7'd1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_prog_nxt    = r_prog;
    w_sel_nxt     = r_field_sel;
    w_edit_nxt    = r_edit;
    w_wr_req_nxt  = r_wr_req;
    w_wr_mode_nxt = r_wr_mode;
    case (r_state)
      ST_IDLE: begin
        if (w_mode != MODE_NONE) begin
          w_state_nxt = ST_EDIT;
          w_prog_nxt  = w_mode;
          w_sel_nxt   = 2'd0;
          w_edit_nxt  = w_load;
        end
      end
      ST_EDIT: begin
        // Leaving the mode wins over any button on the same edge.
        if (w_mode != r_prog) begin
          w_state_nxt   = ST_COMMIT;
          w_wr_mode_nxt = r_prog;
          w_wr_req_nxt  = 1'b1;
          w_prog_nxt    = MODE_NONE;
        end else begin
          w_edit_nxt[r_field_sel] = w_edit_val;
          if (bus.btn_next)
            w_sel_nxt = (r_field_sel == 2'd2) ? 2'd0 : r_field_sel + 2'd1;
        end
      end
      ST_COMMIT: begin
        if (bus.wr_ack && r_wr_req) begin
          w_state_nxt  = ST_IDLE;
          w_wr_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prog      <= MODE_NONE;
      r_field_sel <= 2'd0;
      r_edit      <= '0;
      r_wr_req    <= 1'b0;
      r_wr_mode   <= MODE_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_prog      <= w_prog_nxt;
      r_field_sel <= w_sel_nxt;
      r_edit      <= w_edit_nxt;
      r_wr_req    <= w_wr_req_nxt;
      r_wr_mode   <= w_wr_mode_nxt;
    end
  end

  assign bus.prog      = r_prog;
  assign bus.field_sel = r_field_sel;
  assign bus.edit_data = r_edit;
  assign bus.wr_req    = r_wr_req;
  assign bus.wr_mode   = r_wr_mode;

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// Directed bench for prog_mode_ctrl with DB_CYCLES=4: debounce, decode, editing,
// commit handshake and reset behaviour, against hand-computed expectations.
module tb_prog_mode_ctrl;
  import prog_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_mode_ctrl_if bus();

  prog_mode_ctrl #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       nxt;
    logic       up;
    logic       dn;
    logic [1:0] sel;
    int         f0;
    int         f1;
    int         f2;
  } vec_t;

  vec_t tv [9];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic fields_t pack3(input int f2, input int f1, input int f0);
    return {7'(f2), 7'(f1), 7'(f0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic n, input logic u, input logic d);
    bus.btn_next = n;
    bus.btn_up   = u;
    bus.btn_down = d;
    tick();
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  task automatic chk_out(input string nm, input mode_t p, input logic [1:0] s,
                         input fields_t e, input logic req);
    chk({nm, " prog"},      32'(bus.prog),      32'(p));
    chk({nm, " field_sel"}, 32'(bus.field_sel), 32'(s));
    chk({nm, " edit_data"}, 32'(bus.edit_data), 32'(e));
    chk({nm, " wr_req"},    32'(bus.wr_req),    32'(req));
  endtask

  // Six edges with the old outputs, the seventh shows the new mode's effect.
  task automatic wait_mode_edge(input string nm, input mode_t still_prog);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk({nm, " before accept"}, 32'(bus.prog), 32'(still_prog));
    end
    tick();
  endtask

  initial begin
    // Time-mode edits starting from {sec 30, min 59, hour 23}, field 0.
    tv[0] = '{nxt:1'b0, up:1'b1, dn:1'b0, sel:2'd0, f0:0,  f1:59, f2:30};
    tv[1] = '{nxt:1'b0, up:1'b0, dn:1'b1, sel:2'd0, f0:23, f1:59, f2:30};
    tv[2] = '{nxt:1'b0, up:1'b1, dn:1'b1, sel:2'd0, f0:23, f1:59, f2:30};
    tv[3] = '{nxt:1'b0, up:1'b0, dn:1'b1, sel:2'd0, f0:22, f1:59, f2:30};
    tv[4] = '{nxt:1'b1, up:1'b1, dn:1'b0, sel:2'd1, f0:23, f1:59, f2:30};
    tv[5] = '{nxt:1'b1, up:1'b0, dn:1'b0, sel:2'd2, f0:23, f1:59, f2:30};
    tv[6] = '{nxt:1'b0, up:1'b0, dn:1'b1, sel:2'd2, f0:23, f1:59, f2:29};
    tv[7] = '{nxt:1'b1, up:1'b0, dn:1'b0, sel:2'd0, f0:23, f1:59, f2:29};
    tv[8] = '{nxt:1'b0, up:1'b0, dn:1'b0, sel:2'd0, f0:23, f1:59, f2:29};

    rst_n        = 1'b0;
    bus.sw       = MODE_NONE;
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.snap     = '0;
    bus.wr_ack   = 1'b0;
    repeat (3) tick();
    chk_out("reset", MODE_NONE, 2'd0, '0, 1'b0);
    chk("reset wr_mode", 32'(bus.wr_mode), 32'(MODE_NONE));
    rst_n = 1'b1;

    // Short date pulse must be rejected, then a held date value accepted.
    bus.sw   = MODE_DATE;
    bus.snap = pack3(25, 1, 31);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch prog", 32'(bus.prog), 32'(MODE_NONE));
    end
    bus.sw = MODE_NONE;
    tick();
    chk("glitch gap prog", 32'(bus.prog), 32'(MODE_NONE));
    bus.sw = MODE_DATE;
    wait_mode_edge("date entry", MODE_NONE);
    chk_out("date entry", MODE_DATE, 2'd0, pack3(25, 1, 31), 1'b0);

    // Date wraps: day 31 up -> 1, month 1 down -> 12.
    pulse(1'b0, 1'b1, 1'b0);
    chk("day wrap", 32'(bus.edit_data), 32'(pack3(25, 1, 1)));
    pulse(1'b1, 1'b0, 1'b0);
    chk("date next sel", 32'(bus.field_sel), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("month wrap", 32'(bus.edit_data), 32'(pack3(25, 12, 1)));

    // Switching straight to time commits the date edits first.
    bus.sw   = MODE_TIME;
    bus.snap = pack3(30, 59, 23);
    wait_mode_edge("date->time", MODE_DATE);
    chk_out("date commit", MODE_NONE, 2'd1, pack3(25, 12, 1), 1'b1);
    chk("date commit wr_mode", 32'(bus.wr_mode), 32'(MODE_DATE));
    bus.wr_ack = 1'b1;
    tick();
    chk("date ack wr_req", 32'(bus.wr_req), 32'd0);
    bus.wr_ack = 1'b0;
    tick();
    chk_out("time entry", MODE_TIME, 2'd0, pack3(30, 59, 23), 1'b0);

    for (int i = 0; i < 9; i++) begin
      pulse(tv[i].nxt, tv[i].up, tv[i].dn);
      chk($sformatf("vec%0d sel", i), 32'(bus.field_sel), 32'(tv[i].sel));
      chk($sformatf("vec%0d data", i), 32'(bus.edit_data),
          32'(pack3(tv[i].f2, tv[i].f1, tv[i].f0)));
    end

    // Commit held without ack; buttons must not disturb the frozen data.
    bus.sw = MODE_NONE;
    wait_mode_edge("time exit", MODE_TIME);
    chk_out("time commit", MODE_NONE, 2'd0, pack3(29, 59, 23), 1'b1);
    chk("time commit wr_mode", 32'(bus.wr_mode), 32'(MODE_TIME));
    bus.btn_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold wr_req", 32'(bus.wr_req), 32'd1);
      chk("hold wr_mode", 32'(bus.wr_mode), 32'(MODE_TIME));
      chk("hold edit_data", 32'(bus.edit_data), 32'(pack3(29, 59, 23)));
    end
    bus.btn_up = 1'b0;
    bus.wr_ack = 1'b1;
    tick();
    chk("time ack wr_req", 32'(bus.wr_req), 32'd0);
    bus.wr_ack = 1'b0;
    repeat (3) tick();
    chk_out("idle after ack", MODE_NONE, 2'd0, pack3(29, 59, 23), 1'b0);

    // Two switches on at once is not a mode.
    bus.sw = 3'b011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("invalid prog", 32'(bus.prog), 32'(MODE_NONE));
    end
    chk("invalid wr_req", 32'(bus.wr_req), 32'd0);

    // Timer entry with out-of-range hour and second in the snapshot.
    bus.sw   = MODE_TIMER;
    bus.snap = pack3(70, 20, 30);
    wait_mode_edge("timer entry", MODE_NONE);
    chk_out("timer clamp", MODE_TIMER, 2'd0, pack3(0, 20, 0), 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("timer up", 32'(bus.edit_data), 32'(pack3(0, 20, 1)));

    // Reset in the middle of EDIT.
    rst_n = 1'b0;
    #2;
    chk_out("rst in edit", MODE_NONE, 2'd0, '0, 1'b0);
    chk("rst in edit wr_mode", 32'(bus.wr_mode), 32'(MODE_NONE));
    bus.snap = pack3(5, 6, 7);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post-rst edit wr_req", 32'(bus.wr_req), 32'd0);
    end
    tick();
    chk_out("edit after rst", MODE_TIMER, 2'd0, pack3(5, 6, 7), 1'b0);

    // Reset in the middle of COMMIT.
    bus.sw = MODE_NONE;
    wait_mode_edge("timer exit", MODE_TIMER);
    chk("timer commit wr_req", 32'(bus.wr_req), 32'd1);
    chk("timer commit wr_mode", 32'(bus.wr_mode), 32'(MODE_TIMER));
    rst_n = 1'b0;
    #2;
    chk_out("rst in commit", MODE_NONE, 2'd0, '0, 1'b0);
    chk("rst in commit wr_mode", 32'(bus.wr_mode), 32'(MODE_NONE));
    bus.sw   = MODE_TIMER;
    bus.snap = pack3(1, 2, 3);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post-rst commit wr_req", 32'(bus.wr_req), 32'd0);
    end
    tick();
    chk_out("commit rst re-entry", MODE_TIMER, 2'd0, pack3(1, 2, 3), 1'b0);

    // Ack already high: ignored in EDIT, then wr_req lasts exactly one cycle.
    bus.wr_ack = 1'b1;
    bus.sw     = MODE_NONE;
    wait_mode_edge("early ack", MODE_TIMER);
    chk("min width rise", 32'(bus.wr_req), 32'd1);
    chk("min width wr_mode", 32'(bus.wr_mode), 32'(MODE_TIMER));
    tick();
    chk("min width fall", 32'(bus.wr_req), 32'd0);
    bus.wr_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
